regfile_wb_scheduler: RTL and testbench

- Write-back scheduler and hazard scoreboard for the 32x32 register file.
- Arbitrates N write-back requesters (ALU, load unit, mul/div) onto the register file's single write port.
- Tracks registers with in-flight writes and stalls issue of any instruction that would read or overwrite one of them.
- Sits between the execute-stage units and the register file write port.

---
 rtl/regfile_wb_scheduler.sv | 149 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_scheduler
// Brief   : Write-back arbiter and hazard scoreboard for the 32x32 register file.
//           Define WB_SCHED_RR_EN for round-robin arbitration (default: fixed priority).
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rs1,
  input  logic [4:0]              issue_rs2,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_uses_rd,
  output logic                    issue_stall,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    wb_en,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic [31:0]             busy_vec
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [31:0]        r_busy;
  logic [31:0]        w_busy_nxt;
  logic               r_wb_en;
  logic [4:0]         r_wb_rd;
  logic [XLEN-1:0]    r_wb_data;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_any;
  logic [4:0]         w_sel_rd;
  logic [XLEN-1:0]    w_sel_data;
  logic               w_stall;
  logic               w_set;

`ifdef WB_SCHED_RR_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;

  // First search pass only considers requesters at or after the pointer.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = !(PTR_W'(i) < r_ptr);
    end
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  assign w_elig = '1;
`endif

  // Two passes give the modulo-NUM_REQ wrap: eligible upper part, then from index 0.
  always_comb begin
    w_grant    = '0;
    w_any      = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && req_valid[i] && w_elig[i]) begin
          w_grant[i] = 1'b1;
          w_any      = 1'b1;
          w_sel_rd   = req_rd[i*5 +: 5];
          w_sel_data = req_data[i*XLEN +: XLEN];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && req_valid[i]) begin
          w_grant[i] = 1'b1;
          w_any      = 1'b1;
          w_sel_rd   = req_rd[i*5 +: 5];
          w_sel_data = req_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= w_any;
      if (w_any) begin
        r_wb_rd   <= w_sel_rd;
        r_wb_data <= w_sel_data;
      end
    end
  end

  assign w_stall = issue_valid & (r_busy[issue_rs1] | r_busy[issue_rs2] |
                                  (issue_uses_rd & r_busy[issue_rd]));
  assign w_set   = issue_valid & ~w_stall & issue_uses_rd & (issue_rd != 5'd0);

  // Clear is applied before set so a same-index collision leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wb_en) begin
      w_busy_nxt[r_wb_rd] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign issue_stall = w_stall;
  assign req_ready   = w_grant;
  assign wb_en       = r_wb_en;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign busy_vec    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_scheduler
// Brief   : Directed bench for regfile_wb_scheduler with a per-cycle reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    issue_valid;
  logic [4:0]              issue_rs1;
  logic [4:0]              issue_rs2;
  logic [4:0]              issue_rd;
  logic                    issue_uses_rd;
  logic                    issue_stall;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*5-1:0]    req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    wb_en;
  logic [4:0]              wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic [31:0]             busy_vec;

  int total = 0;
  int bad   = 0;

  regfile_wb_scheduler #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_uses_rd(issue_uses_rd), .issue_stall(issue_stall),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Reference model state: which registers await a write, and the write port.
  logic [31:0]     m_busy    = '0;
  logic            m_wb_en   = 1'b0;
  logic [4:0]      m_wb_rd   = '0;
  logic [XLEN-1:0] m_wb_data = '0;
  int              m_ptr     = 0;

  function automatic int f_start();
`ifdef WB_SCHED_RR_EN
    return m_ptr;
`else
    return 0;
`endif
  endfunction

  function automatic int f_pick(input logic [NUM_REQ-1:0] v, input int start);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic f_stall();
    return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] ||
                           (issue_uses_rd && m_busy[issue_rd]));
  endfunction

  function automatic logic [31:0] f_next_busy();
    logic [31:0] nb;
    nb = m_busy;
    if (m_wb_en) nb[m_wb_rd] = 1'b0;
    if (issue_valid && !f_stall() && issue_uses_rd && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
    nb[0] = 1'b0;
    return nb;
  endfunction

  function automatic logic [NUM_REQ-1:0] f_ready();
    int g;
    logic [NUM_REQ-1:0] r;
    r = '0;
    g = f_pick(req_valid, f_start());
    if (!rst && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= '0;
      m_wb_en   <= 1'b0;
      m_wb_rd   <= '0;
      m_wb_data <= '0;
      m_ptr     <= 0;
    end else begin
      m_busy <= f_next_busy();
      if (f_pick(req_valid, f_start()) >= 0) begin
        m_wb_en   <= 1'b1;
        m_wb_rd   <= req_rd[f_pick(req_valid, f_start())*5 +: 5];
        m_wb_data <= req_data[f_pick(req_valid, f_start())*XLEN +: XLEN];
        m_ptr     <= (f_pick(req_valid, f_start()) + 1) % NUM_REQ;
      end else begin
        m_wb_en <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_ready",   64'(req_ready),   64'(f_ready()));
    chk("model_stall",   64'(issue_stall), 64'(f_stall()));
    chk("model_busy",    64'(busy_vec),    64'(m_busy));
    chk("model_wb_en",   64'(wb_en),       64'(m_wb_en));
    chk("model_wb_rd",   64'(wb_rd),       64'(m_wb_rd));
    chk("model_wb_data", 64'(wb_data),     64'(m_wb_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic uses);
    issue_valid   = v;
    issue_rs1     = rs1;
    issue_rs2     = rs2;
    issue_rd      = rd;
    issue_uses_rd = uses;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                         input logic [XLEN-1:0] d);
    req_valid[i]            = v;
    req_rd[i*5 +: 5]        = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  logic [NUM_REQ-1:0] grants [6];
  logic [NUM_REQ-1:0] exp_g  [6];

  initial begin
    rst = 1'b1;
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_busy",  64'(busy_vec),  64'h0);
    chk("reset_wb_en", 64'(wb_en),     64'h0);
    chk("reset_ready", 64'(req_ready), 64'h0);

    // RAW on x5, resolved by requester 1
    issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    step();
    chk("raw_busy_set", 64'(busy_vec), 64'h20);
    issue(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("raw_stall",  64'(issue_stall), 64'h1);
    chk("raw_ready",  64'(req_ready),   64'h2);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    chk("raw_wb_en",   64'(wb_en),       64'h1);
    chk("raw_wb_rd",   64'(wb_rd),       64'h5);
    chk("raw_wb_data", 64'(wb_data),     64'hDEADBEEF);
    chk("raw_stall_hold", 64'(issue_stall), 64'h1);
    step();
    chk("raw_busy_clr", 64'(busy_vec),    64'h0);
    chk("raw_unstall",  64'(issue_stall), 64'h0);

    // x0 is never tracked
    issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("x0_stall", 64'(issue_stall), 64'h0);
    step();
    chk("x0_busy", 64'(busy_vec), 64'h0);

    // WAW on x7
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    set_req(2, 1'b1, 5'd7, 32'h77);
    #1;
    chk("waw_stall", 64'(issue_stall), 64'h1);
    chk("waw_ready", 64'(req_ready),   64'h4);
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    chk("waw_wb_rd",      64'(wb_rd),       64'h7);
    chk("waw_stall_hold", 64'(issue_stall), 64'h1);
    step();
    chk("waw_busy_clr", 64'(busy_vec), 64'h0);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // set-wins: write to x7 in flight while x7 is issued again
    set_req(0, 1'b1, 5'd7, 32'h700);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    chk("setwin_stall",   64'(issue_stall), 64'h0);
    chk("setwin_wb_data", 64'(wb_data),     64'h700);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("setwin_busy", 64'(busy_vec), 64'h80);
    set_req(1, 1'b1, 5'd7, 32'h7);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    step();
    step();
    chk("cleanup_busy", 64'(busy_vec), 64'h0);

    // write to x0 still occupies the port
    set_req(2, 1'b1, 5'd0, 32'h1234);
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_wb_en", 64'(wb_en), 64'h1);
    chk("x0_wb_rd", 64'(wb_rd), 64'h0);
    step();
    step();

    // Contention: all three valid for six cycles
    set_req(0, 1'b1, 5'd10, 32'hA0);
    set_req(1, 1'b1, 5'd11, 32'hB1);
    set_req(2, 1'b1, 5'd12, 32'hC2);
    for (int i = 0; i < 6; i++) begin
      #1;
      grants[i] = req_ready;
      step();
    end
    req_valid = '0;
`ifdef WB_SCHED_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("contention_grant%0d", i), 64'(grants[i]), 64'(exp_g[i]));
    end
    step();
    step();

    // Back-to-back write-backs to x3 then x9
    issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    step();
    issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("b2b_busy", 64'(busy_vec), 64'h208);
    set_req(0, 1'b1, 5'd3, 32'h33);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b1, 5'd9, 32'h99);
    #1;
    chk("b2b_wb_rd3", 64'(wb_rd), 64'h3);
    chk("b2b_wb_en1", 64'(wb_en), 64'h1);
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    chk("b2b_wb_rd9", 64'(wb_rd),    64'h9);
    chk("b2b_wb_en2", 64'(wb_en),    64'h1);
    chk("b2b_busy9",  64'(busy_vec), 64'h200);
    step();
    chk("b2b_wb_off", 64'(wb_en),    64'h0);
    chk("b2b_clear",  64'(busy_vec), 64'h0);

    // Asynchronous reset mid-operation
    issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
    step();
    issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    set_req(1, 1'b1, 5'd0, 32'h55);
    step();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("pre_rst_busy",  64'(busy_vec), 64'h30);
    chk("pre_rst_wb_en", 64'(wb_en),    64'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy",    64'(busy_vec),  64'h0);
    chk("rst_wb_en",   64'(wb_en),     64'h0);
    chk("rst_ready",   64'(req_ready), 64'h0);
    chk("rst_wb_data", 64'(wb_data),   64'h0);
    step();
    step();
    rst = 1'b0;
    set_req(1, 1'b0, 5'd0, 32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
